// File: rtl/control_edicion_teclado.sv
// Keyboard edit controller: filters PS/2 set-2 break sequences, edits a
// three-field time value (hh/mm/ss) and hands it off through a req/ack write.
module control_edicion_teclado (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tecla,
    input  logic       tecla_valida,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    input  logic       listo,
    output logic       modo_edicion,
    output logic [1:0] campo_sel,
    output logic [7:0] hh_out,
    output logic [7:0] mm_out,
    output logic [7:0] ss_out,
    output logic       solicitud_escritura,
    output logic       guardado
);

    typedef enum logic [1:0] {REPOSO, EDICION, ESCRIBIR} estado_t;

    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_BREAK = 8'hF0;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_SAVE  = 8'h70;
    localparam logic [7:0] K_ESC   = 8'h76;

    estado_t    estado;
    logic       brk;
    logic       make;
    logic [7:0] sel_val;
    logic [7:0] sel_max;
    logic [7:0] inc_val;
    logic [7:0] dec_val;

    // A make code is any byte that is neither a prefix nor the byte after F0.
    assign make = tecla_valida && (tecla != K_EXT) && (tecla != K_BREAK) && !brk;

    always_comb begin
        sel_val = ss_out;
        sel_max = 8'd59;
        case (campo_sel)
            2'd0: begin sel_val = hh_out; sel_max = 8'd23; end
            2'd1: begin sel_val = mm_out; sel_max = 8'd59; end
            default: begin sel_val = ss_out; sel_max = 8'd59; end
        endcase
        inc_val = (sel_val >= sel_max) ? '0 : sel_val + 8'd1;
        dec_val = (sel_val == '0 || sel_val > sel_max) ? sel_max : sel_val - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado              <= REPOSO;
            brk                 <= 1'b0;
            modo_edicion        <= 1'b0;
            campo_sel           <= '0;
            hh_out              <= '0;
            mm_out              <= '0;
            ss_out              <= '0;
            solicitud_escritura <= 1'b0;
            guardado            <= 1'b0;
        end else begin
            guardado <= 1'b0;

            if (tecla_valida) begin
                if (tecla == K_BREAK)
                    brk <= 1'b1;
                else if (tecla != K_EXT && brk)
                    brk <= 1'b0;
            end

            case (estado)
                REPOSO: begin
                    if (make && tecla == K_ENTER) begin
                        hh_out       <= hh_in;
                        mm_out       <= mm_in;
                        ss_out       <= ss_in;
                        campo_sel    <= '0;
                        modo_edicion <= 1'b1;
                        estado       <= EDICION;
                    end
                end
                EDICION: begin
                    if (make) begin
                        case (tecla)
                            K_RIGHT: campo_sel <= (campo_sel == 2'd2) ? 2'd0 : campo_sel + 2'd1;
                            K_LEFT:  campo_sel <= (campo_sel == 2'd0) ? 2'd2 : campo_sel - 2'd1;
                            K_UP, K_DOWN: begin
                                case (campo_sel)
                                    2'd0:    hh_out <= (tecla == K_UP) ? inc_val : dec_val;
                                    2'd1:    mm_out <= (tecla == K_UP) ? inc_val : dec_val;
                                    default: ss_out <= (tecla == K_UP) ? inc_val : dec_val;
                                endcase
                            end
                            K_SAVE: begin
                                solicitud_escritura <= 1'b1;
                                estado              <= ESCRIBIR;
                            end
                            K_ESC: begin
                                modo_edicion <= 1'b0;
                                estado       <= REPOSO;
                            end
                            default: ;
                        endcase
                    end
                end
                ESCRIBIR: begin
                    if (listo) begin
                        solicitud_escritura <= 1'b0;
                        modo_edicion        <= 1'b0;
                        guardado            <= 1'b1;
                        estado              <= REPOSO;
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_control_edicion_teclado.sv
// Scoreboard bench for control_edicion_teclado: a directed pass over the key
// scenarios followed by random key/ack/reset traffic against a reference model.
module tb_control_edicion_teclado;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tecla = '0;
    logic       tecla_valida = 1'b0;
    logic [7:0] hh_in = '0, mm_in = '0, ss_in = '0;
    logic       listo = 1'b0;
    logic       modo_edicion;
    logic [1:0] campo_sel;
    logic [7:0] hh_out, mm_out, ss_out;
    logic       solicitud_escritura;
    logic       guardado;

    control_edicion_teclado dut (
        .clk(clk), .reset(reset), .tecla(tecla), .tecla_valida(tecla_valida),
        .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in), .listo(listo),
        .modo_edicion(modo_edicion), .campo_sel(campo_sel),
        .hh_out(hh_out), .mm_out(mm_out), .ss_out(ss_out),
        .solicitud_escritura(solicitud_escritura), .guardado(guardado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       modo;
        logic [1:0] sel;
        logic [7:0] h, m, s;
        logic       req, g;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "editing" means the user holds a working copy,
    // "writing" means that copy is waiting for the writer's acknowledge.
    bit editing = 0, writing = 0, brk_m = 0, pulse = 0;
    int fld[3] = '{0, 0, 0};
    int sel_m = 0;
    int maxv[3] = '{23, 59, 59};
    logic [7:0] nh = '0, nm = '0, ns = '0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model(input logic r, input logic tv, input logic [7:0] k, input logic l);
        bit mk;
        mk = 0;
        pulse = 0;
        if (!r) begin
            editing = 0; writing = 0; brk_m = 0; sel_m = 0;
            fld = '{0, 0, 0};
            return;
        end
        if (tv) begin
            if (k == 8'hF0) brk_m = 1;
            else if (k == 8'hE0) ;
            else if (brk_m) brk_m = 0;
            else mk = 1;
        end
        if (writing) begin
            if (l) begin writing = 0; editing = 0; pulse = 1; end
        end else if (editing) begin
            if (mk) begin
                case (k)
                    8'h74: sel_m = (sel_m + 1) % 3;
                    8'h6B: sel_m = (sel_m + 2) % 3;
                    8'h75: fld[sel_m] = (fld[sel_m] >= maxv[sel_m]) ? 0 : fld[sel_m] + 1;
                    8'h72: fld[sel_m] = (fld[sel_m] == 0 || fld[sel_m] > maxv[sel_m])
                                        ? maxv[sel_m] : fld[sel_m] - 1;
                    8'h70: writing = 1;
                    8'h76: editing = 0;
                    default: ;
                endcase
            end
        end else if (mk && k == 8'h5A) begin
            fld = '{int'(nh), int'(nm), int'(ns)};
            sel_m = 0;
            editing = 1;
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue the
    // outputs expected after the coming rising edge.
    task automatic step(input logic r, input logic tv, input logic [7:0] k, input logic l);
        exp_t e;
        @(negedge clk);
        #1;
        reset = r; tecla_valida = tv; tecla = k; listo = l;
        hh_in = nh; mm_in = nm; ss_in = ns;
        model(r, tv, k, l);
        e.modo = editing;
        e.sel  = 2'(sel_m);
        e.h    = 8'(fld[0]);
        e.m    = 8'(fld[1]);
        e.s    = 8'(fld[2]);
        e.req  = writing;
        e.g    = pulse;
        exp_q.push_back(e);
    endtask

    task automatic key(input logic [7:0] k);
        step(1'b1, 1'b1, k, 1'b0);
    endtask

    task automatic idle(input int n, input logic l);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, l);
    endtask

    // Monitor: every output sample is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("modo_edicion", {7'd0, modo_edicion}, {7'd0, e.modo});
                chk("campo_sel", {6'd0, campo_sel}, {6'd0, e.sel});
                chk("hh_out", hh_out, e.h);
                chk("mm_out", mm_out, e.m);
                chk("ss_out", ss_out, e.s);
                chk("solicitud_escritura", {7'd0, solicitud_escritura}, {7'd0, e.req});
                chk("guardado", {7'd0, guardado}, {7'd0, e.g});
            end
        end
    end

    logic [7:0] keys[12] = '{8'hE0, 8'hF0, 8'h5A, 8'h74, 8'h6B, 8'h75,
                             8'h72, 8'h70, 8'h76, 8'h75, 8'h72, 8'h29};

    initial begin
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        idle(1, 1'b0);

        // Enter load and hours wrap
        nh = 8'd23; nm = 8'd59; ns = 8'd58;
        key(8'h5A); key(8'h75);
        // Break filtering
        key(8'hF0); key(8'h75);
        key(8'hE0); key(8'h75);
        key(8'hF0); key(8'hE0); key(8'h75);
        key(8'h75);
        // Field select with wrap, decrement at zero and above max
        key(8'h74); key(8'h74); key(8'h74);
        key(8'h6B); key(8'h6B);
        key(8'h76);
        nh = 8'd5; nm = 8'd0; ns = 8'd70;
        key(8'h5A); key(8'h74); key(8'h72); key(8'h74); key(8'h72);
        // Save handshake with keys ignored while writing
        key(8'h70);
        idle(2, 1'b0); key(8'h75); idle(2, 1'b0);
        step(1'b1, 1'b1, 8'h75, 1'b1);
        idle(2, 1'b0);
        // Escape
        key(8'h5A); key(8'h75); key(8'h76); idle(2, 1'b0);
        // Ack already present on first writing cycle
        key(8'h5A); step(1'b1, 1'b1, 8'h70, 1'b1); idle(1, 1'b1); idle(1, 1'b0);
        // Reset mid-request, later ack ignored
        key(8'h5A); key(8'h70); idle(1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            logic r, tv, l;
            if (i % 97 == 0) begin
                nh = 8'($urandom_range(0, 30));
                nm = 8'($urandom_range(0, 70));
                ns = 8'($urandom_range(0, 70));
            end
            r  = ($urandom_range(0, 99) != 0);
            tv = ($urandom_range(0, 1) == 1);
            l  = ($urandom_range(0, 4) == 0);
            step(r, tv, keys[$urandom_range(0, 11)], l);
        end
        idle(2, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_edicion_teclado.md
# control_edicion_teclado

Keyboard-driven edit controller that sequences the capture, modification and saving of a three-field time value (hours, minutes, seconds). It consumes PS/2 set-2 scancode bytes from the keyboard receiver and filters out break sequences. It lets the user select and increment or decrement fields, and on the save key (keypad 0, 8'h70) issues a req/ack write request to the downstream writer. It sits between the keyboard receiver and the register or clock-write path.

## Interface
Parameters: none; field limits are fixed (hh 0–23, mm 0–59, ss 0–59).

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- tecla  in  8  scancode byte from the keyboard receiver
- tecla_valida  in  1  one-cycle strobe; tecla valid when 1
- hh_in, mm_in, ss_in  in  8 each  current time values, binary
- listo  in  1  write acknowledge from downstream writer
- modo_edicion  out  1  1 while in EDICION or ESCRIBIR
- campo_sel  out  2  selected field: 0=hh, 1=mm, 2=ss
- hh_out, mm_out, ss_out  out  8 each  edited values, binary
- solicitud_escritura  out  1  write request, level, held until ack
- guardado  out  1  one-cycle pulse on completed write

## Operation
- States: REPOSO, EDICION, ESCRIBIR. Separate break flag `brk`.
- Byte pre-filter, applied in every state on each tecla_valida:
  - 8'hE0: ignored; brk unchanged.
  - 8'hF0: sets brk; no action.
  - Any other byte with brk=1: clears brk; no action (release code).
  - Otherwise the byte is a make code, passed to the FSM.
- REPOSO:
  - 8'h5A (Enter): load hh/mm/ss_out from hh/mm/ss_in, set campo_sel=0, go to EDICION.
  - All other codes are ignored.
- EDICION, make codes:
  - 8'h74 (right): campo_sel +1, wrapping 2→0.
  - 8'h6B (left): campo_sel −1, wrapping 0→2.
  - 8'h75 (up): selected field +1. If value ≥ max, result is 0.
  - 8'h72 (down): selected field −1. If value = 0, result is max. If value > max, result is max.
  - 8'h70 (save): go to ESCRIBIR.
  - 8'h76 (Esc): go to REPOSO; output values are retained, no request.
  - Other codes are ignored.
- ESCRIBIR:
  - solicitud_escritura=1.
  - hh/mm/ss_out and campo_sel are frozen.
  - All make codes are ignored; brk tracking continues.
  - On listo=1, go to REPOSO with guardado=1 for one cycle.
- listo is ignored outside ESCRIBIR.
- Loaded values above max are kept unchanged until they are edited.

## Timing
- Reset values (reset=0 at an edge): state REPOSO, brk=0, modo_edicion=0, campo_sel=0, hh/mm/ss_out=0, solicitud_escritura=0, guardado=0.
- Reset has priority over every event, including mid-ESCRIBIR. The request drops on the next edge with no guardado pulse.
- Every key action is visible the cycle after the edge that samples tecla_valida=1 (latency 1).
- Enter: hh/mm/ss_in are sampled at that same edge.
- Save: solicitud_escritura rises 1 cycle after the 8'h70 strobe.
- Ack: at the first edge with listo=1 in ESCRIBIR, solicitud_escritura falls, guardado=1 for exactly one cycle, and modo_edicion=0, all visible the next cycle.
  - listo already high on the first ESCRIBIR cycle completes in 1 cycle.
- A tecla_valida arriving on the ack edge is pre-filtered for brk only; its make code is not acted on.
- Back-to-back strobes on consecutive cycles are each processed.

## Test plan
- Reset, then Enter: hh/mm/ss_in=23/59/58; send 5A → modo_edicion=1, outputs 23/59/58, campo_sel=0. Send 75 → hh_out=0 (wrap).
- Break filtering: in EDICION, send F0,75 → no change. Send E0,75 → hh_out +1. Send F0,E0,75 → no change and brk cleared.
- Field select and decrement: send 74,74,74 → campo_sel 1,2,0. Then 74 and 72 with mm=0 → mm_out=59. Load ss_in=70 and send 72 → ss_out=59.
- Save handshake: send 70 → solicitud_escritura=1 next cycle. Hold listo=0 for 5 cycles and send 75 → outputs unchanged. Assert listo → solicitud=0, guardado pulse width 1, modo_edicion=0.
- Escape: in EDICION send 76 → REPOSO, solicitud never asserted, outputs retained.
- Reset mid-request: in ESCRIBIR drive reset=0 for one edge → all outputs at reset values, no guardado. A following listo=1 is ignored.
